// File: rtl/line_fill_responder.sv
// line_fill_responder: memory-side responder for cache line fills.
// A fill request is accepted when idle. After a fixed latency, one cache line
// is streamed from a word-addressed backing store as single-cycle beats,
// separated by a fixed number of idle cycles. A side load port writes the
// backing store at any time. A beat whose data is captured at the same edge
// as a load to the same word sees the old contents.
module line_fill_responder #(
  parameter int LINE_WORDS = 32,
  parameter int LAT        = 2,
  parameter int GAP        = 1,
  parameter int MEM_WORDS  = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        fill_req,
  input  logic [31:0] fill_addr,
  output logic        fill_busy,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data_out,
  output logic        mem_data_valid,
  output logic        mem_last,
  input  logic        load_we,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int BW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int OB = $clog2(LINE_WORDS * 4);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_BEAT = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;

  localparam logic [BW-1:0] LAST_BEAT = BW'(LINE_WORDS - 1);
  localparam logic [3:0]    LAT_C     = 4'(LAT);
  localparam logic [3:0]    GAP_C     = 4'(GAP);
  // Clears the byte offset within a line to form the line base address.
  localparam logic [31:0]   BASE_MASK = ~((32'd1 << OB) - 32'd1);

  // Backing store; deliberately never reset so preloaded contents survive.
  logic [31:0] store_q [MEM_WORDS];

  logic [1:0]    state_q, state_d;
  logic [3:0]    cnt_q,   cnt_d;
  logic [BW-1:0] beat_q,  beat_d;
  logic [31:0]   base_q,  base_d;
  logic [31:0]   addr_q,  addr_d;
  logic [31:0]   data_q,  data_d;

  // Index of the beat that would be presented on the next BEAT entry:
  // beat 0 when leaving WAIT, otherwise the one after the current beat.
  logic [BW-1:0] nxt_beat;
  logic [AW-1:0] rd_idx;
  logic [31:0]   nxt_addr;
  logic          unused_load_bits;

  assign nxt_beat = (state_q == S_GAP) ? beat_q + BW'(1) : '0;
  assign rd_idx   = base_q[AW+1:2] + AW'(nxt_beat);
  assign nxt_addr = base_q + (32'(nxt_beat) << 2);

  // Only the word index of the load address selects a store entry.
  assign unused_load_bits = ^{load_addr[31:AW+2], load_addr[1:0]};

  // Next-state logic for the fill sequencer and beat output registers.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    beat_d  = beat_q;
    base_d  = base_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        if (fill_req) begin
          state_d = S_WAIT;
          base_d  = fill_addr & BASE_MASK;
          // The accept edge already counts as the first latency edge.
          cnt_d   = 4'd1;
          beat_d  = '0;
        end
      end
      S_WAIT: begin
        if (cnt_q == LAT_C) begin
          state_d = S_BEAT;
          beat_d  = nxt_beat;
          addr_d  = nxt_addr;
          data_d  = store_q[rd_idx];
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_BEAT: begin
        if (beat_q == LAST_BEAT) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_GAP;
          cnt_d   = 4'd1;
        end
      end
      default: begin
        if (cnt_q == GAP_C) begin
          state_d = S_BEAT;
          beat_d  = nxt_beat;
          addr_d  = nxt_addr;
          data_d  = store_q[rd_idx];
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
    endcase
  end

  // Sequencer state and beat registers; reset aborts any burst in progress.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      beat_q  <= '0;
      base_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
      base_q  <= base_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  // Load port write; the beat read above samples the pre-write contents.
  always_ff @(posedge clk) begin
    if (load_we) begin
      store_q[load_addr[AW+1:2]] <= load_data;
    end
  end

  assign fill_busy      = (state_q != S_IDLE);
  assign mem_data_valid = (state_q == S_BEAT);
  assign mem_last       = (state_q == S_BEAT) && (beat_q == LAST_BEAT);
  assign mem_addr       = addr_q;
  assign mem_data_out   = data_q;

endmodule

// File: doc/line_fill_responder.md
Name: line_fill_responder

Overview:
Memory-side responder for cache line fills. Accepts a one-cycle fill request carrying a miss address and waits a programmable latency. It then streams one cache line from an internal word-addressed backing store as single-cycle mem_data_valid beats. Each beat carries an incrementing word address, and mem_last marks the final beat. It sits opposite the cache's miss/refill port and doubles as the memory model in cache benches; a side load port preloads and modifies backing-store contents.

Parameters:
LINE_WORDS, 32, words per line (line = LINE_WORDS*4 bytes); power of two, 2..64
LAT, 2, cycles from request-accepting edge to first beat; 1..15
GAP, 1, idle cycles between consecutive beats; 1..15 (valid never high two cycles running)
MEM_WORDS, 1024, backing-store depth in 32-bit words; power of two

Ports:
clk  in  1  clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
fill_req  in  1  one-cycle fill request pulse
fill_addr  in  32  miss byte address, sampled with fill_req
fill_busy  out  1  high from accept until the final beat has been presented
mem_addr  out  32  byte address of the current beat
mem_data_out  out  32  beat data
mem_data_valid  out  1  beat strobe, one cycle per beat
mem_last  out  1  high with the final beat only
load_we  in  1  backing-store write enable
load_addr  in  32  byte address for load write (bits [1:0] ignored)
load_data  in  32  load write data

Behaviour:
- Reset (async assert, sync release): state IDLE; fill_busy=0, mem_addr=0, mem_data_out=0, mem_data_valid=0, mem_last=0; beat and latency counters cleared. Backing store is NOT cleared. Reset mid-burst aborts immediately, with no further beats after release.
- FSM IDLE -> WAIT -> BEAT <-> GAP -> IDLE.
- IDLE: fill_req=1 at an edge is accepted. base = fill_addr with the low log2(LINE_WORDS*4) bits cleared. State moves to WAIT, fill_busy=1 from that edge.
- Requests while fill_busy=1 are ignored, with no queueing. A request in the cycle busy falls is ignored, so the earliest accept is the edge after busy reads 0.
- WAIT: counts LAT edges including the accept edge. The LAT-th edge enters BEAT for beat 0.
- BEAT k (k=0..LINE_WORDS-1): for one cycle, mem_data_valid=1, mem_addr=base+4k, mem_data_out=store[((base>>2)+k) mod MEM_WORDS], and mem_last=(k==LINE_WORDS-1). The next edge enters GAP, or IDLE after the last beat.
- GAP: valid=0 and last=0 for GAP cycles. mem_addr and mem_data_out hold the previous beat's values, then BEAT k+1 follows.
- Beat k valid cycle = accept edge + LAT + k*(GAP+1).
- fill_busy falls at the edge ending the last beat, the same edge mem_data_valid and mem_last fall.
- IDLE outputs: valid=0 and last=0; mem_addr and mem_data_out hold their last values (0 after reset).
- Address arithmetic is 32-bit with natural wrap. Store index = byte address[log2(MEM_WORDS)+1:2], so addresses beyond MEM_WORDS*4 alias.
- Load port works in every state. The write lands at the clock edge. A beat whose data is registered at that same edge for the same word gets the old data (read-before-write); later beats see the new data.
- mem_data_out is registered: it is loaded at the edge entering BEAT, from the store as it was before that edge's load write.

Test Plan:
- Reset: assert reset_n=0 mid-cycle -> all outputs 0 at once; after release with no fill_req, outputs stay 0 and busy=0 for 10 cycles.
- Basic fill (defaults): preload store[i]=32'hAAAAAAAA for even i and 32'h55555555 for odd i; fill_req with fill_addr=32'h0000_0124 at edge 0 -> beats at edges 2,4,...,64. Addresses run 0x100, 0x104 ... 0x17C, data alternates starting 0xAAAAAAAA (index 0x40 is even). Valid is high one cycle each, mem_last only with 0x17C, busy falls at edge 65.
- Request while busy: second fill_req at edge 10 with addr 0x200 -> ignored, exactly 32 beats from 0x100 only; a fill_req at edge 66 is accepted and serves 0x200..0x27C.
- Reset mid-burst: reset_n=0 during beat 5 -> valid/last/busy drop immediately; after release no beats appear until a new fill_req.
- Load collision: during a fill of base 0x000, write load_addr=0x40 (word 16) with 0x55555555 at beat 3 -> beat 16 carries 0x55555555. A write to word 4 at the edge that registers beat 4 -> beat 4 carries the old value.
- Aliasing and parameters: with MEM_WORDS=1024 and fill_addr=0x0000_1000 -> data from store[0..31], mem_addr 0x1000..0x107C. With LAT=5 and GAP=3 -> first beat at edge 5, beats 4 cycles apart, mem_last on beat 31 at edge 129.
